// File: rtl/camera_controller_pkg.sv
// Shared camera definitions: movement key codes, PS/2 set-2
// scan codes, controller FSM states and the scan-code decoder.
package camera_controller_pkg;

  // Bit 0 of every key code is the negate flag.
  typedef enum logic [2:0] {
    UPOS = 3'b000,
    UNEG = 3'b001,
    VPOS = 3'b010,
    VNEG = 3'b011,
    WPOS = 3'b100,
    WNEG = 3'b101
  } key_e;

  localparam logic [7:0] SC_UPOS = 8'h23;
  localparam logic [7:0] SC_UNEG = 8'h1C;
  localparam logic [7:0] SC_VPOS = 8'h24;
  localparam logic [7:0] SC_VNEG = 8'h15;
  localparam logic [7:0] SC_WPOS = 8'h1D;
  localparam logic [7:0] SC_WNEG = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic hit;
    key_e key;
  } scan_t;

  function automatic scan_t decode_scan(input logic [7:0] code);
    scan_t s;
    s.hit = 1'b1;
    s.key = UPOS;
    unique case (code)
      SC_UPOS: s.key = UPOS;
      SC_UNEG: s.key = UNEG;
      SC_VPOS: s.key = VPOS;
      SC_VNEG: s.key = VNEG;
      SC_WPOS: s.key = WPOS;
      SC_WNEG: s.key = WNEG;
      default: s.hit = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/camera_controller_ff_ar_en.sv
// Enabled register with asynchronous active-high reset.
// Ports: clk, rst, en (load enable), d (next value), q (state).
module ff_ar_en #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/camera_controller.sv
// Keyboard-to-camera controller: tracks one held movement key,
// counts the cycles it is held and reports key/count on frame_req.
// Ports: clk, rst (async high), kb_valid/kb_code/kb_break (PS/2
// events), frame_req (report slot), key/cnt/ld_curr_camera (report).
module camera_controller
  import camera_controller_pkg::*;
#(
  parameter logic [31:0] MAX_CNT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kb_valid,
  input  logic [7:0]  kb_code,
  input  logic        kb_break,
  input  logic        frame_req,
  output logic [2:0]  key,
  output logic [31:0] cnt,
  output logic        ld_curr_camera
);

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  key_e        cur_key_q, cur_key_d;

  scan_t       sc;
  logic        press;
  logic        rel_cur;
  logic [31:0] acc_inc;
  logic        rep;
  logic [31:0] rep_cnt;

  assign sc      = decode_scan(kb_code);
  assign press   = kb_valid && sc.hit && !kb_break;
  assign rel_cur = kb_valid && sc.hit && kb_break
                && (sc.key == cur_key_q);

  // Saturating increment; the guard also prevents 32-bit wrap.
  assign acc_inc = (acc_q >= MAX_CNT) ? MAX_CNT : acc_q + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cur_key_q <= UPOS;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cur_key_q <= cur_key_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cur_key_d = cur_key_q;
    rep       = 1'b0;
    rep_cnt   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          cur_key_d = sc.key;
          acc_d     = '0;
          state_d   = ST_HELD;
        end
      end
      ST_HELD: begin
        // The current cycle always counts, even when reported.
        acc_d = acc_inc;
        if (frame_req) begin
          rep     = 1'b1;
          rep_cnt = acc_inc;
          acc_d   = '0;
          if (rel_cur) begin
            state_d = ST_IDLE;
          end
        end else if (rel_cur) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (frame_req) begin
          rep     = 1'b1;
          acc_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
      end
    endcase
  end

  ff_ar_en #(.W(3), .RST_VAL(3'b000)) u_key (
    .clk (clk),
    .rst (rst),
    .en  (rep),
    .d   (cur_key_q),
    .q   (key)
  );

  ff_ar_en #(.W(32), .RST_VAL(32'd0)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (rep),
    .d   (rep_cnt),
    .q   (cnt)
  );

  ff_ar_en #(.W(1), .RST_VAL(1'b0)) u_ld (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (rep),
    .q   (ld_curr_camera)
  );

endmodule

// File: tb/tb_camera_controller.sv
// Self-checking bench for camera_controller: directed scenarios
// followed by random key/frame traffic against a reference model.
module tb_camera_controller;

  localparam logic [31:0] TB_MAX = 32'd100;

  logic        clk = 1'b0;
  logic        rst;
  logic        kb_valid;
  logic [7:0]  kb_code;
  logic        kb_break;
  logic        frame_req;
  logic [2:0]  key;
  logic [31:0] cnt;
  logic        ld_curr_camera;

  int checks = 0;
  int errors = 0;

  // Reference model: which key is tracked, whether it is still
  // down, and how many held cycles are owed to the next report.
  bit          m_trk;
  bit          m_down;
  int          m_k;
  longint      m_n;
  logic        e_ld;
  logic [2:0]  e_key;
  logic [31:0] e_cnt;

  // Index into this table is the key code.
  logic [7:0] sc_tab [6];

  always #5 clk = ~clk;

  camera_controller #(.MAX_CNT(TB_MAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .kb_valid       (kb_valid),
    .kb_code        (kb_code),
    .kb_break       (kb_break),
    .frame_req      (frame_req),
    .key            (key),
    .cnt            (cnt),
    .ld_curr_camera (ld_curr_camera)
  );

  function automatic int lookup(input logic [7:0] c);
    for (int i = 0; i < 6; i++) begin
      if (sc_tab[i] == c) return i;
    end
    return -1;
  endfunction

  task automatic report();
    e_ld  = 1'b1;
    e_key = m_k[2:0];
    e_cnt = m_n[31:0];
  endtask

  task automatic model_step();
    int  idx;
    bit  rel;
    e_ld = 1'b0;
    if (rst) begin
      m_trk  = 0;
      m_down = 0;
      m_n    = 0;
      m_k    = 0;
      e_key  = '0;
      e_cnt  = '0;
      return;
    end
    idx = kb_valid ? lookup(kb_code) : -1;
    rel = (idx == m_k) && kb_break;
    if (!m_trk) begin
      if (idx >= 0 && !kb_break) begin
        m_trk  = 1;
        m_down = 1;
        m_k    = idx;
        m_n    = 0;
      end
    end else if (m_down) begin
      m_n = (m_n + 1 > longint'(TB_MAX)) ? longint'(TB_MAX) : m_n + 1;
      if (frame_req) begin
        report();
        m_n = 0;
        if (rel) m_trk = 0;
      end else if (rel) begin
        m_down = 0;
      end
    end else if (frame_req) begin
      report();
      m_trk = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic v,
                      input logic [7:0] c, input logic b,
                      input logic f);
    rst       = r;
    kb_valid  = v;
    kb_code   = c;
    kb_break  = b;
    frame_req = f;
    model_step();
    @(posedge clk);
    #1;
    chk("ld",  {31'd0, ld_curr_camera}, {31'd0, e_ld});
    chk("key", {29'd0, key}, {29'd0, e_key});
    chk("cnt", cnt, e_cnt);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic press(input logic [7:0] c);
    tick(1'b0, 1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic release_k(input logic [7:0] c);
    tick(1'b0, 1'b1, c, 1'b1, 1'b0);
  endtask

  task automatic frame();
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    int          idx;
    logic        r, v, b, f;
    logic [7:0]  c;
    logic [2:0]  h_key;
    logic [31:0] h_cnt;

    sc_tab = '{8'h23, 8'h1C, 8'h24, 8'h15, 8'h1D, 8'h1B};
    m_trk = 0; m_down = 0; m_k = 0; m_n = 0;
    e_ld = 0; e_key = '0; e_cnt = '0;

    // Reset state
    repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_ld", {31'd0, ld_curr_camera}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    idle(2);

    // Hold W+ for 10 cycles, report 11; then counter restarts
    press(8'h1D);
    idle(10);
    frame();
    chk("r025_ld", {31'd0, ld_curr_camera}, 32'd1);
    chk("r025_key", {29'd0, key}, 32'd4);
    chk("r025_cnt", cnt, 32'd11);
    idle(1);
    chk("pulse_one", {31'd0, ld_curr_camera}, 32'd0);
    chk("hold_cnt", cnt, 32'd11);
    idle(2);
    frame();
    chk("restart_cnt", cnt, 32'd4);
    release_k(8'h1D);
    idle(3);
    frame();
    chk("flush_cnt", cnt, 32'd1);
    idle(2);

    // U- held 6 cycles, released, reported 20 cycles later
    press(8'h1C);
    idle(5);
    release_k(8'h1C);
    idle(20);
    frame();
    chk("r026_key", {29'd0, key}, 32'd1);
    chk("r026_cnt", cnt, 32'd6);
    frame();
    chk("r026_idle", {31'd0, ld_curr_camera}, 32'd0);

    // Second key ignored while U+ is tracked
    press(8'h23);
    idle(2);
    press(8'h15);
    idle(2);
    release_k(8'h15);
    frame();
    chk("r027_key", {29'd0, key}, 32'd0);
    chk("r027_cnt", cnt, 32'd7);
    // Release and report together: back to idle, no flush
    tick(1'b0, 1'b1, 8'h23, 1'b1, 1'b1);
    chk("relrep_cnt", cnt, 32'd1);
    frame();
    chk("relrep_idle", {31'd0, ld_curr_camera}, 32'd0);

    // Saturation at the ceiling
    press(8'h24);
    idle(120);
    frame();
    chk("sat_cnt", cnt, TB_MAX);
    idle(150);
    release_k(8'h24);
    idle(5);
    frame();
    chk("sat_flush", cnt, TB_MAX);

    // Idle frame and unmapped code leave outputs untouched
    h_key = key;
    h_cnt = cnt;
    frame();
    press(8'h76);
    idle(3);
    frame();
    chk("r029_ld", {31'd0, ld_curr_camera}, 32'd0);
    chk("r029_key", {29'd0, key}, {29'd0, h_key});
    chk("r029_cnt", cnt, h_cnt);

    // Reset mid-hold discards the pending count
    press(8'h24);
    idle(3);
    repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    frame();
    chk("r030_ld", {31'd0, ld_curr_camera}, 32'd0);
    chk("r030_key", {29'd0, key}, 32'd0);
    chk("r030_cnt", cnt, 32'd0);
    // First press after reset
    press(8'h1B);
    idle(1);
    frame();
    chk("post_rst_key", {29'd0, key}, 32'd5);
    chk("post_rst_cnt", cnt, 32'd2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 399) == 0);
      v   = ($urandom_range(0, 3) == 0);
      idx = $urandom_range(0, 6);
      c   = (idx < 6) ? sc_tab[idx] : 8'h76;
      b   = $urandom_range(0, 1) == 1;
      f   = ($urandom_range(0, 9) == 0);
      tick(r, v, c, b, f);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_controller.md
CAMERA_CONTROLLER -- requirements
Module: camera_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with the ports named clk and rst as elsewhere in the codebase.
REQ-002 Port list:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- kb_valid  in  1  one-cycle strobe; kb_code/kb_break are valid this cycle
- kb_code  in  8  PS/2 set-2 scan code
- kb_break  in  1  1 = key release, 0 = key press
- frame_req  in  1  one-cycle pulse; camera may update now
- key  out  3  movement code for the camera datapath
- cnt  out  32  cycles the key was held since the last report
- ld_curr_camera  out  1  one-cycle pulse; key/cnt are valid
REQ-003 Parameter MAX_CNT, default 32'hFFFF_FFFF, is the saturation ceiling for the held-cycle counter.

Function
REQ-004 Scan-code map: 8'h23->UPOS, 8'h1C->UNEG, 8'h24->VPOS, 8'h15->VNEG, 8'h1D->WPOS, 8'h1B->WNEG.
- Key codes: UPOS=000, UNEG=001, VPOS=010, VNEG=011, WPOS=100, WNEG=101.
- Bit 0 of the key code is the negate flag.
REQ-005 kb_valid strobes whose code is unmapped SHALL be ignored in every state.
REQ-006 FSM states:
- IDLE: no key tracked.
- HELD: a key is pressed and the counter is running.
- FLUSH: the key has been released and its count awaits a report.
REQ-007 IDLE, mapped press: cur_key<=code, acc<=0, go to HELD.
REQ-008 HELD: acc SHALL increment by 1 every cycle and saturate at MAX_CNT (no wrap).
REQ-009 HELD, release of cur_key: acc freezes (this cycle still counts), go to FLUSH.
REQ-010 HELD, press or release of any other mapped key: ignored (single-key tracking).
REQ-011 HELD, frame_req: on the next edge, key<=cur_key, cnt<=acc+1 (saturated), ld_curr_camera<=1, acc<=0; counting continues and the state stays HELD.
REQ-012 HELD, frame_req and release of cur_key in the same cycle: report as in REQ-011, then go to IDLE (no FLUSH visit).
REQ-013 FLUSH, frame_req: on the next edge, key<=cur_key, cnt<=acc, ld_curr_camera<=1, then go to IDLE.
REQ-014 FLUSH: all kb_valid strobes SHALL be ignored until the report is made.
REQ-015 IDLE, frame_req: no report; ld_curr_camera stays 0.
REQ-016 ld_curr_camera SHALL be high for exactly one cycle per report, with a latency of 1 cycle from frame_req.
REQ-017 key and cnt SHALL be registered outputs that hold their last reported value between reports.
REQ-018 A report with cnt=0 SHALL NOT occur; a report is made only when HELD or FLUSH is active.

Reset
REQ-019 While rst is high the block SHALL hold: state=IDLE, acc=0, cur_key=000, key=000, cnt=0, ld_curr_camera=0.
REQ-020 rst asserted mid-HELD or mid-FLUSH SHALL discard the pending count and emit no report after rst is released.
REQ-021 The first press after reset SHALL be handled as in REQ-007.

Structure
REQ-022 The key-code constants (UPOS..WNEG) and the scan-code constants SHALL live in the shared camera package, so that camera_datapath and this block use one definition.
REQ-023 The key, cnt and ld_curr_camera registers SHALL use the existing ff_ar_en sub-module.
REQ-024 The FSM, counter and scan-code decode SHALL be inline; no other sub-module is needed.

Verification
REQ-025 Press 8'h1D, wait 10 cycles, frame_req -> next cycle: ld_curr_camera=1, key=100, cnt=11; acc then restarts from 0.
REQ-026 Press 8'h1C, release after 5 cycles, frame_req 20 cycles later -> key=001, cnt=6, state=IDLE.
REQ-027 Press 8'h23, then press 8'h15 while HELD, then frame_req -> key=000; the 8'h15 press has no effect.
REQ-028 Force acc to MAX_CNT-2, hold for 10 cycles, frame_req -> cnt=32'hFFFF_FFFF (saturated, no wrap).
REQ-029 frame_req while IDLE, and an unmapped code 8'h76 -> ld_curr_camera stays 0 and the outputs are unchanged.
REQ-030 Press 8'h24, assert rst for 3 cycles, then frame_req -> no ld_curr_camera pulse; key=000, cnt=0.
